// File: rtl/mem_stage_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_pkg
// Shared definitions for the MEM-stage access controller:
//   state_t         - controller FSM encoding (IDLE=0, REQ=1, DONE=2)
//   LANE_*          - big-endian byte-lane select codes (address bits [1:0])
//   TIMEOUT_DEFAULT - default request timeout in cycles
//   cnt_width()     - width of the timeout counter for a given TIMEOUT
// -----------------------------------------------------------------------------
package mem_stage_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Big-endian lanes: the lowest byte address holds the most significant byte.
   localparam logic [1:0] LANE_31_24 = 2'd0;
   localparam logic [1:0] LANE_23_16 = 2'd1;
   localparam logic [1:0] LANE_15_8  = 2'd2;
   localparam logic [1:0] LANE_7_0   = 2'd3;

   localparam int TIMEOUT_DEFAULT = 15;

   // Counter must be able to represent TIMEOUT itself.
   function automatic int cnt_width(input int timeout);
      return $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_stage_ctrl_if
// Data-memory request/acknowledge bus between the MEM-stage controller
// (master) and a variable-latency data memory (slave).
//   mem_req   - request, held high until acknowledged or aborted
//   mem_we    - 1 = write, 0 = read
//   mem_addr  - word-aligned byte address
//   mem_wdata - write data
//   mem_ack   - acknowledge from memory
//   mem_rdata - read data, valid together with mem_ack
// -----------------------------------------------------------------------------
interface mem_stage_ctrl_if;

   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_ack, mem_rdata
   );

endinterface

// File: rtl/mem_stage_ctrl_load_align.sv
// -----------------------------------------------------------------------------
// load_align
// Combinational load formatter: picks a big-endian byte out of a memory word
// and sign- or zero-extends it, or passes the whole word through.
//   i_word     - 32-bit word returned by memory
//   i_addr_lsb - byte offset within the word
//   i_lb       - 1 = byte load, 0 = word load
//   i_ext      - byte load only: 1 = sign-extend, 0 = zero-extend
//   o_data     - formatted load result
// -----------------------------------------------------------------------------
module load_align
   import mem_stage_pkg::*;
(
   input  logic [31:0] i_word,
   input  logic [1:0]  i_addr_lsb,
   input  logic        i_lb,
   input  logic        i_ext,
   output logic [31:0] o_data
);

   logic [7:0] w_byte;

   always_comb begin
      w_byte = i_word[31:24];
      case (i_addr_lsb)
         LANE_31_24: w_byte = i_word[31:24];
         LANE_23_16: w_byte = i_word[23:16];
         LANE_15_8:  w_byte = i_word[15:8];
         LANE_7_0:   w_byte = i_word[7:0];
         default:    w_byte = i_word[31:24];
      endcase
   end

   always_comb begin
      o_data = i_word;
      if (i_lb) begin
         o_data = {{24{i_ext & w_byte[7]}}, w_byte};
      end
   end

endmodule

// File: rtl/mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// mem_stage_ctrl
// MEM-stage access controller. Takes the EX/MEM register contents, runs one
// request/acknowledge transaction per load/store against a variable-latency
// data memory, stalls the pipeline meanwhile and returns formatted load data.
// Misaligned word accesses, read+write conflicts and timeouts pulse o_mem_error.
//   i_clk, i_rst      - clock, asynchronous active-high reset
//   i_mem_read        - load requested
//   i_mem_write       - store requested
//   i_lb              - byte load (ignored for stores)
//   i_load_extended   - byte load sign-extend (1) / zero-extend (0)
//   i_alu_result      - byte address
//   i_rd2             - store data
//   o_stall           - hold pipeline registers (combinational)
//   o_read_data       - load result, valid in DONE (registered)
//   o_mem_error       - one-cycle error pulse (registered)
//   mem_bus           - data-memory bus, master side
// -----------------------------------------------------------------------------
module mem_stage_ctrl
   import mem_stage_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT
)(
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_mem_read,
   input  logic               i_mem_write,
   input  logic               i_lb,
   input  logic               i_load_extended,
   input  logic [31:0]        i_alu_result,
   input  logic [31:0]        i_rd2,
   output logic               o_stall,
   output logic [31:0]        o_read_data,
   output logic               o_mem_error,
   mem_stage_ctrl_if.master   mem_bus
);

   localparam int             CW        = cnt_width(TIMEOUT);
   localparam logic [CW-1:0]  TIMEOUT_C = CW'(TIMEOUT);

   state_t        r_state;
   state_t        w_state_next;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_inc;

   logic          r_mem_req;
   logic          r_mem_we;
   logic [31:0]   r_mem_addr;
   logic [31:0]   r_mem_wdata;
   logic          r_lb;
   logic          r_ext;
   logic [1:0]    r_addr_lsb;
   logic [31:0]   r_read_data;
   logic          r_mem_error;

   logic          w_access;
   logic          w_byte_load;
   logic          w_legal;
   logic          w_illegal;
   logic          w_stall;
   logic          w_launch;
   logic          w_ack_done;
   logic          w_timeout;
   logic          w_error_set;
   logic [31:0]   w_load_data;

   // Decode of the instruction currently sitting in EX/MEM.
   assign w_access    = i_mem_read ^ i_mem_write;
   assign w_byte_load = i_lb & i_mem_read & ~i_mem_write;
   // Byte loads may use any offset; everything else must be word aligned.
   assign w_legal     = w_access & (w_byte_load | (i_alu_result[1:0] == 2'b00));
   assign w_illegal   = (i_mem_read & i_mem_write) | (w_access & ~w_legal);

   always_comb begin
      w_state_next = r_state;
      w_stall      = 1'b0;
      w_launch     = 1'b0;
      w_ack_done   = 1'b0;
      w_timeout    = 1'b0;
      w_error_set  = 1'b0;
      w_cnt_inc    = r_cnt + CW'(1);
      case (r_state)
         ST_IDLE: begin
            if (w_legal) begin
               w_stall      = 1'b1;
               w_launch     = 1'b1;
               w_state_next = ST_REQ;
            end else if (w_illegal) begin
               w_error_set  = 1'b1;
            end
         end
         ST_REQ: begin
            w_stall = 1'b1;
            // Ack is checked first so an ack on the final cycle still wins.
            if (mem_bus.mem_ack) begin
               w_ack_done   = 1'b1;
               w_state_next = ST_DONE;
            end else if (w_cnt_inc == TIMEOUT_C) begin
               w_timeout    = 1'b1;
               w_error_set  = 1'b1;
               w_state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            // EX/MEM advances on the negedge inside DONE, so IDLE sees the
            // next instruction and the finished access is not relaunched.
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   load_align u_load_align (
      .i_word     (mem_bus.mem_rdata),
      .i_addr_lsb (r_addr_lsb),
      .i_lb       (r_lb),
      .i_ext      (r_ext),
      .o_data     (w_load_data)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_lb        <= 1'b0;
         r_ext       <= 1'b0;
         r_addr_lsb  <= '0;
         r_read_data <= '0;
         r_mem_error <= 1'b0;
         r_cnt       <= '0;
      end else begin
         r_mem_error <= w_error_set;
         if (w_launch) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= i_mem_write;
            r_mem_addr  <= {i_alu_result[31:2], 2'b00};
            r_mem_wdata <= i_rd2;
            r_lb        <= w_byte_load;
            r_ext       <= i_load_extended;
            r_addr_lsb  <= i_alu_result[1:0];
            r_cnt       <= '0;
         end else if (r_state == ST_REQ) begin
            if (w_ack_done | w_timeout) begin
               r_mem_req <= 1'b0;
            end else begin
               r_cnt     <= w_cnt_inc;
            end
         end
         if (w_ack_done) begin
            r_read_data <= r_mem_we ? 32'd0 : w_load_data;
         end else if (w_timeout) begin
            r_read_data <= 32'd0;
         end
      end
   end

   assign o_stall           = w_stall;
   assign o_read_data       = r_read_data;
   assign o_mem_error       = r_mem_error;
   assign mem_bus.mem_req   = r_mem_req;
   assign mem_bus.mem_we    = r_mem_we;
   assign mem_bus.mem_addr  = r_mem_addr;
   assign mem_bus.mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_ctrl
// Directed bench for mem_stage_ctrl. Pipeline inputs change on the negedge
// (like the EX/MEM register) whenever stall is low; the memory side is a
// scripted responder that acks on a chosen request cycle.
// -----------------------------------------------------------------------------
module tb_mem_stage_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_read;
   logic        mem_write;
   logic        lb;
   logic        ext;
   logic [31:0] alu;
   logic [31:0] rd2;
   logic        stall;
   logic [31:0] read_data;
   logic        mem_error;

   int checks   = 0;
   int failures = 0;

   // Per-transaction observations
   int          t_stall;
   int          t_req;
   int          t_rises;
   int          t_err;
   int          t_bad;
   logic        t_done;
   logic        t_done_err;
   logic        t_done_stall;
   logic [31:0] t_rdata;

   always #5 clk = ~clk;

   mem_stage_ctrl_if bus ();

   mem_stage_ctrl #(.TIMEOUT(15)) dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_mem_read      (mem_read),
      .i_mem_write     (mem_write),
      .i_lb            (lb),
      .i_load_extended (ext),
      .i_alu_result    (alu),
      .i_rd2           (rd2),
      .o_stall         (stall),
      .o_read_data     (read_data),
      .o_mem_error     (mem_error),
      .mem_bus         (bus)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic set_nop();
      mem_read  = 1'b0;
      mem_write = 1'b0;
      lb        = 1'b0;
      ext       = 1'b0;
      alu       = 32'd0;
      rd2       = 32'd0;
   endtask

   // wait_n: request cycles without ack before acking (-1 = never ack)
   task automatic run_tx(input string name, input logic rd, input logic wr,
                         input logic b, input logic ex, input logic [31:0] addr,
                         input logic [31:0] wdata, input int wait_n,
                         input logic [31:0] mem_word);
      int          iter;
      int          post;
      logic        prev_req;
      logic        r_now;
      logic        s_now;
      logic [31:0] exp_addr;
      exp_addr     = {addr[31:2], 2'b00};
      t_stall      = 0;
      t_req        = 0;
      t_rises      = 0;
      t_err        = 0;
      t_bad        = 0;
      t_done       = 1'b0;
      t_done_err   = 1'b0;
      t_done_stall = 1'b1;
      t_rdata      = 32'd0;
      @(negedge clk);
      mem_read  = rd;
      mem_write = wr;
      lb        = b;
      ext       = ex;
      alu       = addr;
      rd2       = wdata;
      #2;
      if (stall) t_stall++;
      prev_req = 1'b0;
      iter     = 0;
      post     = 0;
      while (iter < 40) begin
         @(negedge clk);
         iter++;
         r_now = bus.mem_req;
         s_now = stall;
         if (mem_error) t_err++;
         if (r_now) begin
            t_req++;
            if (!prev_req) t_rises++;
            if (bus.mem_addr !== exp_addr || bus.mem_we !== wr ||
                (wr && bus.mem_wdata !== wdata)) t_bad++;
         end
         if (t_done) post++;
         if (prev_req && !r_now && !t_done) begin
            t_done       = 1'b1;
            t_rdata      = read_data;
            t_done_err   = mem_error;
            t_done_stall = s_now;
         end
         prev_req      = r_now;
         bus.mem_ack   = r_now && (wait_n >= 0) && (t_req == wait_n + 1);
         bus.mem_rdata = bus.mem_ack ? mem_word : 32'h5A5A_5A5A;
         if (!s_now) set_nop();
         #2;
         if (stall) t_stall++;
         if ((t_done && post >= 2) || (t_rises == 0 && iter >= 4)) break;
      end
      bus.mem_ack = 1'b0;
      $display("TX %-10s addr=0x%08h stall=%0d req=%0d err=%0d rdata=0x%08h",
               name, addr, t_stall, t_req, t_err, t_rdata);
   endtask

   initial begin
      int cnt;
      int errs;
      rst           = 1'b1;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 32'd0;
      set_nop();

      // Reset state
      @(negedge clk);
      chk("rst_req",   32'(bus.mem_req), 32'd0);
      chk("rst_we",    32'(bus.mem_we),  32'd0);
      chk("rst_addr",  bus.mem_addr,     32'd0);
      chk("rst_wdata", bus.mem_wdata,    32'd0);
      chk("rst_rdata", read_data,        32'd0);
      chk("rst_err",   32'(mem_error),   32'd0);
      chk("rst_stall", 32'(stall),       32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Word load, two wait cycles
      run_tx("ld_w_0x10", 1, 0, 0, 0, 32'h10, 32'h0, 2, 32'hDEAD_BEEF);
      chk("ldw_done",   32'(t_done),       32'd1);
      chk("ldw_stall",  t_stall,           32'd4);
      chk("ldw_req",    t_req,             32'd3);
      chk("ldw_rises",  t_rises,           32'd1);
      chk("ldw_bus",    t_bad,             32'd0);
      chk("ldw_rdata",  t_rdata,           32'hDEAD_BEEF);
      chk("ldw_err",    t_err,             32'd0);
      chk("ldw_dstall", 32'(t_done_stall), 32'd0);

      // Byte loads, ack on first request cycle
      run_tx("lb_13_sx", 1, 0, 1, 1, 32'h13, 32'h0, 0, 32'h1234_5680);
      chk("lb13s_rdata", t_rdata, 32'hFFFF_FF80);
      chk("lb13s_stall", t_stall, 32'd2);
      run_tx("lb_13_zx", 1, 0, 1, 0, 32'h13, 32'h0, 0, 32'h1234_5680);
      chk("lb13z_rdata", t_rdata, 32'h0000_0080);
      chk("lb13z_bus",   t_bad,   32'd0);
      run_tx("lb_10_sx", 1, 0, 1, 1, 32'h10, 32'h0, 0, 32'h1234_5680);
      chk("lb10_rdata",  t_rdata, 32'h0000_0012);
      run_tx("lb_11_zx", 1, 0, 1, 0, 32'h11, 32'h0, 0, 32'h1234_5680);
      chk("lb11_rdata",  t_rdata, 32'h0000_0034);
      run_tx("lb_12_sx", 1, 0, 1, 1, 32'h12, 32'h0, 0, 32'h1234_D680);
      chk("lb12_rdata",  t_rdata, 32'hFFFF_FFD6);

      // Stray ack while idle is ignored
      @(negedge clk);
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      bus.mem_ack   = 1'b0;
      chk("idle_ack_req",   32'(bus.mem_req), 32'd0);
      chk("idle_ack_rdata", read_data,        32'hFFFF_FFD6);
      chk("idle_ack_err",   32'(mem_error),   32'd0);

      // Timeout: no ack at all
      run_tx("ld_tmo", 1, 0, 0, 0, 32'h80, 32'h0, -1, 32'h0);
      chk("tmo_done",  32'(t_done),     32'd1);
      chk("tmo_req",   t_req,           32'd15);
      chk("tmo_stall", t_stall,         32'd16);
      chk("tmo_err",   t_err,           32'd1);
      chk("tmo_derr",  32'(t_done_err), 32'd1);
      chk("tmo_rdata", t_rdata,         32'd0);

      // Store with one wait cycle
      run_tx("st_0x20", 0, 1, 0, 0, 32'h20, 32'hCAFE_F00D, 1, 32'h0);
      chk("st_req",    t_req,             32'd2);
      chk("st_rises",  t_rises,           32'd1);
      chk("st_bus",    t_bad,             32'd0);
      chk("st_stall",  t_stall,           32'd3);
      chk("st_dstall", 32'(t_done_stall), 32'd0);
      chk("st_rdata",  t_rdata,           32'd0);
      chk("st_err",    t_err,             32'd0);

      // Illegal accesses
      run_tx("ld_mis_06", 1, 0, 0, 0, 32'h06, 32'h0, 0, 32'h1111_1111);
      chk("mis_req",   t_req,   32'd0);
      chk("mis_stall", t_stall, 32'd0);
      chk("mis_err",   t_err,   32'd1);
      run_tx("rd_and_wr", 1, 1, 0, 0, 32'h20, 32'h55, 0, 32'h1111_1111);
      chk("rw_req",    t_req,   32'd0);
      chk("rw_stall",  t_stall, 32'd0);
      chk("rw_err",    t_err,   32'd1);
      run_tx("st_lb_21", 0, 1, 1, 0, 32'h21, 32'h55, 0, 32'h1111_1111);
      chk("stlb_req",  t_req,   32'd0);
      chk("stlb_err",  t_err,   32'd1);

      // Ack on the very cycle the counter reaches TIMEOUT
      run_tx("ld_ack15", 1, 0, 0, 0, 32'h100, 32'h0, 14, 32'hA5A5_0001);
      chk("ack15_req",   t_req,   32'd15);
      chk("ack15_stall", t_stall, 32'd16);
      chk("ack15_err",   t_err,   32'd0);
      chk("ack15_rdata", t_rdata, 32'hA5A5_0001);

      // Reset during the third request cycle
      @(negedge clk);
      mem_read = 1'b1;
      alu      = 32'h30;
      rd2      = 32'h77;
      cnt      = 0;
      for (int i = 0; i < 10 && cnt < 3; i++) begin
         @(negedge clk);
         if (bus.mem_req) cnt++;
      end
      chk("mid_reach", cnt, 32'd3);
      set_nop();
      #1 rst = 1'b1;
      #1;
      chk("mid_req",   32'(bus.mem_req), 32'd0);
      chk("mid_we",    32'(bus.mem_we),  32'd0);
      chk("mid_addr",  bus.mem_addr,     32'd0);
      chk("mid_wdata", bus.mem_wdata,    32'd0);
      chk("mid_rdata", read_data,        32'd0);
      chk("mid_err",   32'(mem_error),   32'd0);
      @(negedge clk);
      rst  = 1'b0;
      errs = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (mem_error || bus.mem_req) errs++;
      end
      chk("mid_quiet", errs, 32'd0);
      $display("TX %-10s reset in REQ cycle %0d", "rst_mid", cnt);

      // Back-to-back load after reset
      run_tx("ld_after", 1, 0, 0, 0, 32'h40, 32'h0, 0, 32'h0BAD_F00D);
      chk("after_done",  32'(t_done), 32'd1);
      chk("after_stall", t_stall,     32'd2);
      chk("after_rdata", t_rdata,     32'h0BAD_F00D);
      chk("after_err",   t_err,       32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Memory-stage access controller at the consuming end of the EX/MEM pipeline register. It takes the registered MEM-stage control and data (MemRead, MemWrite, Lb, LoadExtended, ALU result as address, RD2 as store data) and runs a request/acknowledge transaction against a variable-latency data memory. It stalls the pipeline until the access completes and returns aligned, extended load data to the MEM/WB path. Misaligned accesses, conflicting commands and memory timeouts are reported on an error flag.

## Interface
- TIMEOUT, 15, max cycles MemReqOut stays high without MemAckIn before abort (1..255)
- Clk  in  1  clock; all state updates on posedge
- Reset  in  1  asynchronous, active-high
- MemReadIn  in  1  load requested (from EX/MEM)
- MemWriteIn  in  1  store requested
- LbIn  in  1  byte load (ignored when MemWriteIn=1)
- LoadExtendedIn  in  1  byte load: 1 = sign-extend, 0 = zero-extend
- ALUResultIn  in  32  byte address
- RD2In  in  32  store data
- Stall  out  1  hold pipeline registers while high
- ReadDataOut  out  32  load result, valid in DONE
- MemErrorOut  out  1  one-cycle error pulse
- MemReqOut  out  1  memory request
- MemWeOut  out  1  1 = write
- MemAddrOut  out  32  word address ({addr[31:2],2'b00})
- MemWDataOut  out  32  write data
- MemAckIn  in  1  memory acknowledge
- MemRDataIn  in  32  memory read data, valid with MemAckIn

## Operation
- States: IDLE, REQ, DONE (2-bit encoding).
- IDLE: access = MemReadIn XOR MemWriteIn. Legal if access and (LbIn&MemReadIn, or ALUResultIn[1:0]==0). Legal -> Stall=1 combinationally, latch addr/wdata/we/lb/ext at posedge, go REQ.
- Illegal (MemReadIn&MemWriteIn, or misaligned word access): no request, Stall=0, MemErrorOut=1 for the next cycle, stay IDLE.
- REQ: MemReqOut=1, Stall=1; MemAddrOut/MemWeOut/MemWDataOut come from latched values and stay stable while MemReqOut=1. MemAckIn sampled high at posedge -> capture MemRDataIn, go DONE. A timeout counter increments each REQ cycle; when it reaches TIMEOUT with no ack -> drop request, MemErrorOut pulse, ReadDataOut=0, go DONE.
- DONE: Stall=0, MemReqOut=0, ReadDataOut held; always returns to IDLE next posedge. The EX/MEM negedge inside DONE loads the next instruction, so the completed access is never relaunched.
- Load formatting: word load -> ReadDataOut=MemRDataIn. Byte load is big-endian: addr[1:0]=0 -> bits 31:24, 1 -> 23:16, 2 -> 15:8, 3 -> 7:0. Extended per the latched LoadExtended. Stores: ReadDataOut=0.
- MemAckIn while MemReqOut=0: ignored.

## Timing
- Reset (async): state IDLE, MemReqOut=0, MemWeOut=0, MemAddrOut=0, MemWDataOut=0, ReadDataOut=0, MemErrorOut=0, counter=0. Stall then follows the IDLE combinational rule. Reset in REQ aborts without error.
- Latency, ack at first REQ cycle: detect (IDLE) -> REQ -> DONE. Stall high for 2 cycles; data valid 2 cycles after detect.
- Latency with N wait cycles: Stall high for N+2 cycles.
- Timeout: MemReqOut high for exactly TIMEOUT cycles. Error pulse coincides with the DONE cycle.
- Ack arriving in the same cycle the counter reaches TIMEOUT: the ack wins and no error is raised.
- Outputs MemReqOut/MemWeOut/MemAddrOut/MemWDataOut/ReadDataOut/MemErrorOut are registered. Stall is combinational from state plus IDLE inputs.

## Structure
- Package mem_stage_pkg: state encoding (IDLE=0, REQ=1, DONE=2), byte-lane select constants, counter width derived as clog2(TIMEOUT+1).
- Sub-module load_align: combinational byte select plus sign/zero extension (inputs: 32-bit word, addr[1:0], lb, ext). Kept separate so the MEM/WB forwarding logic can reuse it.

## Test plan
- Word load at 0x0000_0010, memory acks after 2 wait cycles with 0xDEADBEEF -> Stall high 4 cycles, MemAddrOut=0x10, ReadDataOut=0xDEADBEEF in DONE, MemErrorOut=0.
- Lb at 0x13, LoadExtended=1, word 0x1234_5680 -> ReadDataOut=0xFFFF_FF80. Same with LoadExtended=0 -> 0x0000_0080. Lb at 0x10 -> 0x0000_0012.
- Store 0xCAFEF00D to 0x20 -> MemWeOut=1, MemWDataOut stable for every request cycle, single transaction, Stall low in DONE.
- Word load at 0x0000_0006, and separately MemRead=MemWrite=1 -> no MemReqOut, Stall=0, MemErrorOut pulses exactly 1 cycle.
- No ack with TIMEOUT=15 -> MemReqOut high 15 cycles, then MemErrorOut pulse, ReadDataOut=0, return to IDLE. Separately, ack arriving exactly on cycle 15 -> no error.
- Reset asserted mid-REQ (cycle 3) -> MemReqOut drops immediately, state IDLE, all registered outputs 0, no error pulse. A back-to-back load after reset completes normally.
